// File: rtl/gpio_edge_ts_pkg.sv
// Shared types and constants for the GPIO change-capture block.
// Holds default sizes, the record layout and the drop-counter helper.
package gpio_edge_ts_pkg;

  localparam int unsigned DropCntWidth   = 16;
  localparam int unsigned DefaultWidth   = 32;
  localparam int unsigned DefaultTsWidth = 32;
  localparam int unsigned DefaultDepth   = 8;

  // Field order matches the FIFO data word: ts in the MSBs, changed mask in the LSBs.
  typedef struct packed {
    logic [DefaultTsWidth-1:0] ts;
    logic [DefaultWidth-1:0]   data;
    logic [DefaultWidth-1:0]   changed;
  } evt_rec_t;

  function automatic logic [DropCntWidth-1:0] sat_inc(input logic [DropCntWidth-1:0] v);
    return (&v) ? v : v + DropCntWidth'(1);
  endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous show-ahead FIFO with flush; accepts a write when full if a read happens that cycle.
// Read data is forced to zero while empty so outputs are deterministic after reset.
module prim_fifo_sync #(
  parameter int unsigned Width = 16,
  parameter bit          Pass  = 1'b0,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     wvalid_i,
  output logic                     wready_o,
  input  logic [Width-1:0]         wdata_i,
  output logic                     rvalid_o,
  input  logic                     rready_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   depth_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned DepthW = PtrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [DepthW-1:0] cnt_q, cnt_d;
  logic              fifo_rvalid, full, push, pop, pass_thru;

  assign fifo_rvalid = (cnt_q != '0);
  assign full        = (cnt_q == DepthW'(Depth));
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign wready_o    = ~full | rready_i;
  assign pop         = fifo_rvalid & rready_i;
  assign push        = wvalid_i & wready_o & ~pass_thru;
  assign depth_o     = cnt_q;

  always_comb begin
    rvalid_o  = fifo_rvalid;
    rdata_o   = fifo_rvalid ? mem_q[rptr_q] : '0;
    pass_thru = 1'b0;
    if (Pass && !fifo_rvalid) begin
      rvalid_o  = wvalid_i;
      rdata_o   = wvalid_i ? wdata_i : '0;
      pass_thru = wvalid_i & rready_i;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DepthW'(push) - DepthW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (clr_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PtrW'(1);
        if (pop)  rptr_q <= rptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gpio_edge_timestamp.sv
// Timestamped change capture on the filtered GPIO vector.
// Each masked pin change becomes a {ts, snapshot, changed} record queued for a consumer.
module gpio_edge_timestamp
  import gpio_edge_ts_pkg::*;
#(
  parameter int unsigned Width   = DefaultWidth,
  parameter int unsigned TsWidth = DefaultTsWidth,
  parameter int unsigned Depth   = DefaultDepth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic [Width-1:0]        gpio_i,
  input  logic [Width-1:0]        mask_i,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [Width-1:0]        evt_data_o,
  output logic [Width-1:0]        evt_changed_o,
  output logic [TsWidth-1:0]      evt_ts_o,
  output logic [$clog2(Depth):0]  depth_o,
  output logic                    overflow_o,
  output logic [DropCntWidth-1:0] drop_cnt_o
);

  localparam int unsigned RecWidth = TsWidth + 2 * Width;

  logic [Width-1:0]        gpio_q, change;
  logic                    primed_q;
  logic [TsWidth-1:0]      ts_q;
  logic                    push, wready, drop;
  logic                    overflow_q;
  logic [DropCntWidth-1:0] drop_cnt_q;
  logic [RecWidth-1:0]     rdata;

  assign change = (gpio_i ^ gpio_q) & mask_i;
  // primed_q masks the first post-reset sample, whose gpio_q is the reset value.
  assign push   = primed_q & en_i & ~clear_i & (|change);
  assign drop   = push & ~wready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_q     <= '0;
      primed_q   <= 1'b0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      gpio_q   <= gpio_i;
      primed_q <= 1'b1;
      ts_q     <= clear_i ? '0 : ts_q + TsWidth'(1);
      if (clear_i) begin
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        drop_cnt_q <= sat_inc(drop_cnt_q);
      end
    end
  end

  prim_fifo_sync #(
    .Width (RecWidth),
    .Pass  (1'b0),
    .Depth (Depth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clear_i),
    .wvalid_i (push),
    .wready_o (wready),
    .wdata_i  ({ts_q, gpio_i, change}),
    .rvalid_o (evt_valid_o),
    .rready_i (evt_ready_i),
    .rdata_o  (rdata),
    .depth_o  (depth_o)
  );

  assign evt_ts_o      = rdata[RecWidth-1 -: TsWidth];
  assign evt_data_o    = rdata[2*Width-1 -: Width];
  assign evt_changed_o = rdata[Width-1:0];
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_gpio_edge_timestamp.sv
// Directed bench for gpio_edge_timestamp: capture, masking, overflow, clear and ts wrap.
module tb_gpio_edge_timestamp;

  localparam int unsigned Width   = 32;
  localparam int unsigned TsWidth = 32;
  localparam int unsigned Depth   = 8;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               en_i, clear_i, evt_ready_i;
  logic [Width-1:0]   gpio_i, mask_i;
  logic               evt_valid_o, overflow_o;
  logic [Width-1:0]   evt_data_o, evt_changed_o;
  logic [TsWidth-1:0] evt_ts_o;
  logic [3:0]         depth_o;
  logic [15:0]        drop_cnt_o;

  gpio_edge_timestamp #(
    .Width   (Width),
    .TsWidth (TsWidth),
    .Depth   (Depth)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .clear_i       (clear_i),
    .gpio_i        (gpio_i),
    .mask_i        (mask_i),
    .evt_valid_o   (evt_valid_o),
    .evt_ready_i   (evt_ready_i),
    .evt_data_o    (evt_data_o),
    .evt_changed_o (evt_changed_o),
    .evt_ts_o      (evt_ts_o),
    .depth_o       (depth_o),
    .overflow_o    (overflow_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;  // cycles since reset release or clear == expected ts_q

  logic [31:0] exp_data [9];
  logic [31:0] exp_chg  [9];
  logic [31:0] exp_ts   [9];
  logic [31:0] prev;
  int unsigned t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    if (!rst_ni || clear_i) cyc = 0;
    else cyc = cyc + 1;
    #1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    en_i        = 1'b1;
    clear_i     = 1'b0;
    evt_ready_i = 1'b0;
    gpio_i      = 32'hFFFF_FFFF;
    mask_i      = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", 64'(evt_valid_o), 64'd0);
    check("rst_depth", 64'(depth_o), 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
    check("rst_data", 64'(evt_data_o), 64'd0);
    check("rst_ts", 64'(evt_ts_o), 64'd0);
    rst_ni = 1'b1;
    cyc    = 0;

    // No spurious record after reset; first real change at ts = 10.
    repeat (10) step();
    check("no_rec_after_reset", 64'(evt_valid_o), 64'd0);
    gpio_i = 32'hFFFF_FFFE;
    step();
    check("first_valid", 64'(evt_valid_o), 64'd1);
    check("first_data", 64'(evt_data_o), 64'hFFFF_FFFE);
    check("first_changed", 64'(evt_changed_o), 64'h0000_0001);
    check("first_ts", 64'(evt_ts_o), 64'd10);
    check("first_depth", 64'(depth_o), 64'd1);
    evt_ready_i = 1'b1;
    step();
    evt_ready_i = 1'b0;
    check("pop_valid", 64'(evt_valid_o), 64'd0);
    check("pop_depth", 64'(depth_o), 64'd0);

    // Masking: bits 0 and 4 toggle, only bit 4 watched.
    mask_i = 32'h0000_00F0;
    gpio_i = 32'hFFFF_FFEF;
    t      = cyc;
    step();
    check("mask_valid", 64'(evt_valid_o), 64'd1);
    check("mask_changed", 64'(evt_changed_o), 64'h0000_0010);
    check("mask_data", 64'(evt_data_o), 64'hFFFF_FFEF);
    check("mask_ts", 64'(evt_ts_o), 64'(t));
    evt_ready_i = 1'b1;
    step();
    evt_ready_i = 1'b0;
    gpio_i = 32'hFFFF_FFEE;
    step();
    check("bit0_masked", 64'(evt_valid_o), 64'd0);
    mask_i = 32'hFFFF_FFFF;
    step();
    check("mask_toggle", 64'(evt_valid_o), 64'd0);
    en_i   = 1'b0;
    gpio_i = 32'hFFFF_FFEF;
    step();
    check("en_low", 64'(evt_valid_o), 64'd0);
    en_i = 1'b1;
    step();
    check("en_toggle", 64'(depth_o), 64'd0);

    // Twelve back-to-back changes into an 8-deep FIFO with no consumer.
    prev = 32'hFFFF_FFEF;
    for (int i = 0; i < 12; i++) begin
      gpio_i = 32'(i + 1);
      if (i < 8) begin
        exp_data[i] = gpio_i;
        exp_chg[i]  = gpio_i ^ prev;
        exp_ts[i]   = cyc;
      end
      prev = gpio_i;
      step();
    end
    check("ovf_depth", 64'(depth_o), 64'd8);
    check("ovf_flag", 64'(overflow_o), 64'd1);
    check("ovf_drop", 64'(drop_cnt_o), 64'd4);
    check("ovf_head", 64'(evt_data_o), 64'h1);
    check("ovf_head_chg", 64'(evt_changed_o), 64'hFFFF_FFEE);

    // Full: push and pop together keeps occupancy and drops nothing.
    gpio_i      = 32'hD;
    exp_data[8] = 32'hD;
    exp_chg[8]  = 32'h1;
    exp_ts[8]   = cyc;
    evt_ready_i = 1'b1;
    step();
    evt_ready_i = 1'b0;
    check("full_pp_depth", 64'(depth_o), 64'd8);
    check("full_pp_drop", 64'(drop_cnt_o), 64'd4);

    evt_ready_i = 1'b1;
    for (int i = 1; i < 9; i++) begin
      check($sformatf("drain%0d_valid", i), 64'(evt_valid_o), 64'd1);
      check($sformatf("drain%0d_data", i), 64'(evt_data_o), 64'(exp_data[i]));
      check($sformatf("drain%0d_chg", i), 64'(evt_changed_o), 64'(exp_chg[i]));
      check($sformatf("drain%0d_ts", i), 64'(evt_ts_o), 64'(exp_ts[i]));
      step();
    end
    evt_ready_i = 1'b0;
    check("drain_empty", 64'(evt_valid_o), 64'd0);
    check("drain_depth", 64'(depth_o), 64'd0);

    // Clear with 5 records held and a change in the clear cycle.
    for (int i = 0; i < 5; i++) begin
      gpio_i = 32'h100 << i;
      step();
    end
    check("pre_clear_depth", 64'(depth_o), 64'd5);
    clear_i = 1'b1;
    gpio_i  = 32'hABCD;
    step();
    clear_i = 1'b0;
    check("clr_depth", 64'(depth_o), 64'd0);
    check("clr_valid", 64'(evt_valid_o), 64'd0);
    check("clr_drop", 64'(drop_cnt_o), 64'd0);
    check("clr_overflow", 64'(overflow_o), 64'd0);
    gpio_i = 32'hABCC;
    step();
    check("post_clr_ts", 64'(evt_ts_o), 64'd0);
    check("post_clr_chg", 64'(evt_changed_o), 64'h1);
    step();
    check("clr_change_lost", 64'(depth_o), 64'd1);
    evt_ready_i = 1'b1;
    step();
    evt_ready_i = 1'b0;

    // Timestamp wrap.
    gpio_i = 32'hABCD;
    force dut.ts_q = 32'hFFFF_FFFF;
    #1;
    release dut.ts_q;
    step();
    gpio_i = 32'hABCC;
    step();
    check("wrap_depth", 64'(depth_o), 64'd2);
    check("wrap_ts_max", 64'(evt_ts_o), 64'hFFFF_FFFF);
    evt_ready_i = 1'b1;
    step();
    check("wrap_ts_zero", 64'(evt_ts_o), 64'd0);
    check("wrap_chg", 64'(evt_changed_o), 64'h1);
    step();
    evt_ready_i = 1'b0;
    check("wrap_empty", 64'(evt_valid_o), 64'd0);

    // Asynchronous reset mid-operation.
    gpio_i = 32'h0;
    step();
    check("pre_rst_depth", 64'(depth_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", 64'(evt_valid_o), 64'd0);
    check("async_rst_depth", 64'(depth_o), 64'd0);
    step();
    rst_ni = 1'b1;
    step();
    check("post_rst_valid", 64'(evt_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_edge_timestamp.md
# gpio_edge_timestamp

Timestamped change-capture stage placed directly downstream of the GPIO input filter. It consumes the filtered 32-bit input vector and detects any change on the unmasked pins. Each change is stored as a {timestamp, pin snapshot, changed-bit mask} record in a small FIFO, which a consumer drains over a valid/ready handshake. Overflow is reported with a sticky flag and a saturating drop counter. Software can use this block to reconstruct pin waveforms without interrupt latency.

## Interface
Parameters:
- Width, 32, number of GPIO pins captured.
- TsWidth, 32, timestamp counter width.
- Depth, 8, FIFO entries; must be a power of two and at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- en_i  in  1  capture enable; when low, no records are pushed.
- clear_i  in  1  synchronous flush of the FIFO, timestamp, drop counter and overflow flag.
- gpio_i  in  Width  filtered pin vector, synchronous to clk_i.
- mask_i  in  Width  per-pin capture enable; 1 = pin is watched.
- evt_valid_o  out  1  head record available.
- evt_ready_i  in  1  consumer accepts head record.
- evt_data_o  out  Width  pin snapshot at the time of the change.
- evt_changed_o  out  Width  pins that changed, after masking.
- evt_ts_o  out  TsWidth  timestamp of the change.
- depth_o  out  $clog2(Depth)+1  current FIFO occupancy.
- overflow_o  out  1  sticky: at least one record was dropped.
- drop_cnt_o  out  16  dropped-record count; saturates at 16'hFFFF.

## Operation
Reset values of all outputs and state:
- evt_valid_o = 0, depth_o = 0, overflow_o = 0, drop_cnt_o = 0.
- evt_data_o, evt_changed_o and evt_ts_o = 0.
- Timestamp counter ts_q = 0; previous-sample register gpio_q = 0; primed flag = 0.

Sampling and change detection:
- gpio_q <= gpio_i every cycle, regardless of en_i and clear_i.
- primed is set on the first cycle after reset. While primed = 0, no change is detected, so no spurious record appears after reset.
- change = (gpio_i ^ gpio_q) & mask_i.

Timestamp:
- ts_q increments by 1 every cycle and wraps modulo 2^TsWidth.
- clear_i forces ts_q to 0 in the next cycle.

Push:
- A push is requested when primed && en_i && !clear_i && change != 0.
- The record is {ts_q, gpio_i, change}, all taken in the same cycle.

FIFO and handshake:
- The FIFO is show-ahead: the head record is presented on the outputs while evt_valid_o = 1.
- A pop occurs when evt_valid_o && evt_ready_i.
- While evt_valid_o is high, the outputs stay stable until the pop.
- When evt_valid_o = 0, the evt_* data outputs are don't-care.

Boundary conditions:
- Full with push and pop in the same cycle: both occur and occupancy is unchanged. No drop.
- Full with push and no pop: the record is dropped, overflow_o is set, and drop_cnt_o increments (saturating).
- Empty with push and pop requested: no pop occurs (valid is 0) and the push is accepted.
- clear_i: the FIFO empties next cycle; drop_cnt_o and overflow_o go to 0. A push or pop in the same cycle is discarded and not counted as a drop.
- Toggling mask_i or en_i does not generate events by itself.
- Reset asserted mid-operation returns all state to reset values asynchronously.

## Timing
- A change visible on gpio_i in cycle N is pushed at the end of cycle N. With an empty FIFO, evt_valid_o is 1 in cycle N+1 and evt_ts_o equals the ts_q value of cycle N.
- The last record is popped in cycle M; evt_valid_o is 0 in cycle M+1.
- Back-to-back changes on consecutive cycles produce one record per cycle, with timestamps differing by exactly 1.
- Throughput: one push and one pop per cycle sustained.
- There is no combinational path from evt_ready_i to evt_valid_o.
- depth_o and overflow_o update one cycle after the causing event.

## Structure
- Package gpio_edge_ts_pkg holds:
  - DropCntWidth = 16.
  - Default Width, TsWidth and Depth.
  - A record struct typedef {ts, data, changed} for the default widths.
- FIFO: use the existing prim_fifo_sync (Pass = 0, Depth = Depth) with the record concatenated as its data word.
- Change detection, timestamp, primed flag and drop counter live in the top module; no other sub-module.

## Test plan
- Reset with gpio_i = 32'hFFFF_FFFF and mask_i = all-ones → no record after reset. Then drive gpio_i = 32'hFFFF_FFFE at the cycle where ts = 10 → one record: data = FFFF_FFFE, changed = 0000_0001, ts = 10.
- mask_i = 32'h0000_00F0; toggle bits 0 and 4 together → one record with changed = 0000_0010. Toggling bit 0 alone produces no record.
- Depth = 8, evt_ready_i = 0, 12 single-cycle changes → depth_o = 8, overflow_o = 1, drop_cnt_o = 4. Then drain → 8 records in order with increasing timestamps.
- FIFO full, push and pop in the same cycle → depth_o stays 8 and drop_cnt_o is unchanged.
- clear_i asserted while 5 records are held and a change occurs → next cycle depth_o = 0, evt_valid_o = 0, ts = 0, drop_cnt_o = 0. The change in the clear cycle is lost.
- Force ts_q to 2^TsWidth-1 → the change in that cycle has ts = FFFF_FFFF and the next-cycle change has ts = 0.
